// File: rtl/fifo_nibble_packer.sv
`default_nettype none
// ============================================================================
// fifo_nibble_packer : packs FIFO nibble pairs into bytes on a 2-deep valid/ready queue; PACKER_PARITY_EN adds out_parity
// Rev 1.0
// ============================================================================
module fifo_nibble_packer #(
  parameter bit LSN_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fifo_data_out,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        nib_pending,
  output logic [15:0] byte_count
`ifdef PACKER_PARITY_EN
  ,
  output logic        out_parity
`endif
);

  typedef enum logic [0:0] {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  hold, hold_nxt;
  logic        inflight;
  logic        capture;
  logic        push;
  logic        pop_q;
  logic [7:0]  packed_byte;
  logic [2:0]  committed;

  logic [7:0]  q_data [2];
  logic [1:0]  q_count;
  logic        wr_ptr;
  logic        rd_ptr;

  // Worst-case nibbles that may still land in the queue: two per stored byte,
  // plus a held half and one on the FIFO bus. Four means the queue is spoken for.
  assign committed   = {q_count, 1'b0} + {2'b00, nib_pending} + {2'b00, inflight};
  assign fifo_rd_en  = !rst && !fifo_empty && (committed < 3'd4);
  assign capture     = inflight;
  assign nib_pending = (state == S_SECOND);
  assign packed_byte = LSN_FIRST ? {fifo_data_out, hold} : {hold, fifo_data_out};

  assign out_valid   = (q_count != 2'd0);
  assign out_data    = q_data[rd_ptr];
  assign pop_q       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FIRST;
      hold     <= 4'h0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      if (fifo_rd_en)
        inflight <= 1'b1;
      else if (capture)
        inflight <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    push      = 1'b0;
    case (state)
      S_FIRST: begin
        if (capture) begin
          hold_nxt  = fifo_data_out;
          state_nxt = S_SECOND;
        end
      end
      S_SECOND: begin
        if (capture) begin
          push      = 1'b1;
          state_nxt = S_FIRST;
        end
      end
      default: state_nxt = S_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_data[0]  <= 8'h00;
      q_data[1]  <= 8'h00;
      q_count    <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      byte_count <= 16'h0000;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= packed_byte;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop_q) begin
        rd_ptr     <= ~rd_ptr;
        byte_count <= byte_count + 16'd1;
      end
      case ({push, pop_q})
        2'b10:   q_count <= q_count + 2'd1;
        2'b01:   q_count <= q_count - 2'd1;
        default: q_count <= q_count;
      endcase
    end
  end

`ifdef PACKER_PARITY_EN
  logic q_par [2];

  assign out_parity = q_par[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_par[0] <= 1'b0;
      q_par[1] <= 1'b0;
    end else if (push) begin
      q_par[wr_ptr] <= ^packed_byte;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_nibble_packer.sv
`default_nettype none
// tb_fifo_nibble_packer : randomized self-checking bench; two DUTs (LSN_FIRST=1/0) share one FIFO model.
module tb_fifo_nibble_packer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        out_ready = 1'b0;
  logic        empty_force0 = 1'b0;
  logic        model_empty;
  logic        fifo_empty;
  logic [3:0]  fifo_data_out = 4'h0;

  logic        rd_en1, rd_en0, valid1, valid0, pend1, pend0;
  logic [7:0]  data1, data0;
  logic [15:0] cnt1, cnt0;
`ifdef PACKER_PARITY_EN
  logic        par1, par0;
`endif

  fifo_nibble_packer #(.LSN_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en1), .out_data(data1), .out_valid(valid1), .out_ready(out_ready),
    .nib_pending(pend1), .byte_count(cnt1)
`ifdef PACKER_PARITY_EN
    , .out_parity(par1)
`endif
  );

  fifo_nibble_packer #(.LSN_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en0), .out_data(data0), .out_valid(valid0), .out_ready(out_ready),
    .nib_pending(pend0), .byte_count(cnt0)
`ifdef PACKER_PARITY_EN
    , .out_parity(par0)
`endif
  );

  // FIFO model: writes from the stimulus side, registered pops driven by dut1
  logic [3:0] fmem [1024];
  int wr_idx = 0;
  int rd_idx = 0;
  int pops   = 0;
  int cyc    = 0;

  assign model_empty = (rd_idx == wr_idx);
  assign fifo_empty  = model_empty && !empty_force0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      rd_idx        <= wr_idx;
      fifo_data_out <= 4'h0;
    end else if (rd_en1 && !fifo_empty && (rd_idx != wr_idx)) begin
      fifo_data_out <= fmem[rd_idx % 1024];
      rd_idx        <= rd_idx + 1;
      pops          <= pops + 1;
    end
  end

  // Records every byte handed over downstream (handshake stable across negedge)
  logic [7:0] g1 [1024];
  logic [7:0] g0 [1024];
  logic       gp1 [1024];
  int gn = 0;

  always @(negedge clk) begin
    if (!rst && valid1 && out_ready) begin
      g1[gn % 1024] <= data1;
      g0[gn % 1024] <= valid0 ? data0 : 8'hxx;
`ifdef PACKER_PARITY_EN
      gp1[gn % 1024] <= par1;
`else
      gp1[gn % 1024] <= 1'b0;
`endif
      gn <= gn + 1;
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int gbase   = 0;
  logic [3:0] nq [$];

  function automatic logic [7:0] pack(input logic [3:0] first, input logic [3:0] second, input bit lsn);
    return lsn ? {second, first} : {first, second};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_nib(input logic [3:0] v);
    fmem[wr_idx % 1024] = v;
    wr_idx = wr_idx + 1;
    nq.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    nq.delete();
    gbase = gn;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      tick(1);
      if (gn - gbase >= n) ok = 1'b1;
    end
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    empty_force0 = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    tick(1);
    n_total++; if (rd_en1 !== 1'b0) $display("FAIL reset_rd_en1 got=%b exp=0", rd_en1); else n_pass++;
    n_total++; if (rd_en0 !== 1'b0) $display("FAIL reset_rd_en0 got=%b exp=0", rd_en0); else n_pass++;
    tick(1);
    n_total++; if (rd_en1 !== 1'b0) $display("FAIL reset_rd_en1_c2 got=%b exp=0", rd_en1); else n_pass++;
    n_total++; if (valid1 !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid1); else n_pass++;
    n_total++; if (data1 !== 8'h00) $display("FAIL reset_data got=%h exp=00", data1); else n_pass++;
    n_total++; if (cnt1 !== 16'h0) $display("FAIL reset_count got=%h exp=0000", cnt1); else n_pass++;
    n_total++; if (pend1 !== 1'b0) $display("FAIL reset_pending got=%b exp=0", pend1); else n_pass++;
`ifdef PACKER_PARITY_EN
    n_total++; if (par1 !== 1'b0) $display("FAIL reset_parity got=%b exp=0", par1); else n_pass++;
`endif
    rst = 1'b0;
    empty_force0 = 1'b0;
    nq.delete();
    gbase = gn;
  endtask

  task automatic test_stream();
    int p0, pe, fv, dc;
    logic [7:0] e1, e0;
    do_reset();
    out_ready = 1'b1;
    p0 = pops; pe = -1; fv = -1; dc = -1;
    for (int i = 0; i < 17; i++) write_nib(4'(i));
    for (int c = 0; c < 100 && dc < 0; c++) begin
      tick(1);
      if (pe < 0 && pops != p0) pe = cyc;
      if (fv < 0 && valid1) fv = cyc;
      if (gn - gbase >= 8) dc = cyc;
    end
    tick(4);
    n_total++; if (gn - gbase != 8) $display("FAIL stream_nbytes got=%0d exp=8", gn - gbase); else n_pass++;
    n_total++; if (fv - pe != 2) $display("FAIL stream_latency got=%0d exp=2", fv - pe); else n_pass++;
    n_total++; if (dc - pe != 17) $display("FAIL stream_throughput got=%0d exp=17", dc - pe); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      e1 = pack(nq[2*i], nq[2*i+1], 1'b1);
      e0 = pack(nq[2*i], nq[2*i+1], 1'b0);
      n_total++; if (g1[(gbase+i)%1024] !== e1) $display("FAIL stream_byte_lsn1[%0d] got=%h exp=%h", i, g1[(gbase+i)%1024], e1); else n_pass++;
      n_total++; if (g0[(gbase+i)%1024] !== e0) $display("FAIL stream_byte_lsn0[%0d] got=%h exp=%h", i, g0[(gbase+i)%1024], e0); else n_pass++;
`ifdef PACKER_PARITY_EN
      n_total++; if (gp1[(gbase+i)%1024] !== ^e1) $display("FAIL stream_parity[%0d] got=%b exp=%b", i, gp1[(gbase+i)%1024], ^e1); else n_pass++;
`endif
    end
    n_total++; if (cnt1 !== 16'd8) $display("FAIL stream_count got=%0d exp=8", cnt1); else n_pass++;
    n_total++; if (cnt0 !== 16'd8) $display("FAIL stream_count_lsn0 got=%0d exp=8", cnt0); else n_pass++;
    n_total++; if (pend1 !== 1'b1) $display("FAIL stream_odd_pending got=%b exp=1", pend1); else n_pass++;
    n_total++; if (pops - p0 != 17) $display("FAIL stream_pops got=%0d exp=17", pops - p0); else n_pass++;
  endtask

  task automatic test_order();
    int p0, pe, fv;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    p0 = pops; pe = -1; fv = -1;
    write_nib(4'hA);
    write_nib(4'h5);
    for (int c = 0; c < 20 && fv < 0; c++) begin
      tick(1);
      if (pe < 0 && pops != p0) pe = cyc;
      if (fv < 0 && valid1) fv = cyc;
    end
    wait_bytes(1, ok);
    n_total++; if (fv - pe != 2) $display("FAIL order_latency got=%0d exp=2", fv - pe); else n_pass++;
    n_total++; if (!ok || gn - gbase != 1) $display("FAIL order_nbytes got=%0d exp=1", gn - gbase); else n_pass++;
    n_total++; if (g0[gbase%1024] !== 8'hA5) $display("FAIL order_lsn0 got=%h exp=a5", g0[gbase%1024]); else n_pass++;
    n_total++; if (g1[gbase%1024] !== 8'h5A) $display("FAIL order_lsn1 got=%h exp=5a", g1[gbase%1024]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int p0;
    bit ok;
    logic [7:0] e1, e0;
    do_reset();
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) write_nib(4'(i));
    tick(12);
    n_total++; if (pops - p0 != 4) $display("FAIL bp_pops_stalled got=%0d exp=4", pops - p0); else n_pass++;
    n_total++; if (valid1 !== 1'b1) $display("FAIL bp_valid got=%b exp=1", valid1); else n_pass++;
    n_total++; if (data1 !== 8'h10) $display("FAIL bp_head got=%h exp=10", data1); else n_pass++;
    n_total++; if (pend1 !== 1'b0) $display("FAIL bp_pending got=%b exp=0", pend1); else n_pass++;
    tick(3);
    n_total++; if (data1 !== 8'h10) $display("FAIL bp_head_stable got=%h exp=10", data1); else n_pass++;
    n_total++; if (data0 !== 8'h01) $display("FAIL bp_head_lsn0 got=%h exp=01", data0); else n_pass++;
`ifdef PACKER_PARITY_EN
    n_total++; if (par1 !== 1'b1) $display("FAIL bp_parity got=%b exp=1", par1); else n_pass++;
`endif
    out_ready = 1'b1;
    tick(1);
    n_total++; if (pops - p0 != 4) $display("FAIL bp_no_early_pop got=%0d exp=4", pops - p0); else n_pass++;
    tick(1);
    n_total++; if (pops - p0 != 5) $display("FAIL bp_resume_pop got=%0d exp=5", pops - p0); else n_pass++;
    wait_bytes(4, ok);
    n_total++; if (!ok || gn - gbase != 4) $display("FAIL bp_nbytes got=%0d exp=4", gn - gbase); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      e1 = pack(nq[2*i], nq[2*i+1], 1'b1);
      e0 = pack(nq[2*i], nq[2*i+1], 1'b0);
      n_total++; if (g1[(gbase+i)%1024] !== e1) $display("FAIL bp_byte_lsn1[%0d] got=%h exp=%h", i, g1[(gbase+i)%1024], e1); else n_pass++;
      n_total++; if (g0[(gbase+i)%1024] !== e0) $display("FAIL bp_byte_lsn0[%0d] got=%h exp=%h", i, g0[(gbase+i)%1024], e0); else n_pass++;
    end
    n_total++; if (cnt1 !== 16'd4) $display("FAIL bp_count got=%0d exp=4", cnt1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found, ok;
    logic [7:0] e1;
    // continues from a drained, byte-aligned state so byte_count is nonzero
    nq.delete();
    gbase = gn;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_nib(4'($urandom_range(0, 15)));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick(1);
      if (valid1) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL mid_first_byte got=timeout exp=valid"); else n_pass++;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_total++; if (valid1 !== 1'b0) $display("FAIL mid_valid got=%b exp=0", valid1); else n_pass++;
    n_total++; if (pend1 !== 1'b0) $display("FAIL mid_pending got=%b exp=0", pend1); else n_pass++;
    n_total++; if (cnt1 !== 16'h0) $display("FAIL mid_count got=%0d exp=0", cnt1); else n_pass++;
    n_total++; if (data1 !== 8'h00) $display("FAIL mid_data got=%h exp=00", data1); else n_pass++;
    nq.delete();
    gbase = gn;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) write_nib(4'($urandom_range(0, 15)));
    wait_bytes(3, ok);
    n_total++; if (!ok || gn - gbase != 3) $display("FAIL mid_nbytes got=%0d exp=3", gn - gbase); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      e1 = pack(nq[2*i], nq[2*i+1], 1'b1);
      n_total++; if (g1[(gbase+i)%1024] !== e1) $display("FAIL mid_byte[%0d] got=%h exp=%h", i, g1[(gbase+i)%1024], e1); else n_pass++;
    end
    n_total++; if (cnt1 !== 16'd3) $display("FAIL mid_count_after got=%0d exp=3", cnt1); else n_pass++;
  endtask

  task automatic test_random(input int round);
    int n, written, nb, p0;
    bit ok;
    logic [7:0] e1, e0;
    do_reset();
    p0 = pops;
    n = $urandom_range(10, 40);
    written = 0;
    for (int c = 0; c < 400 && written < n; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        write_nib(4'($urandom_range(0, 15)));
        written++;
      end
      tick(1);
    end
    out_ready = 1'b1;
    nb = nq.size() / 2;
    wait_bytes(nb, ok);
    n_total++; if (!ok || gn - gbase != nb) $display("FAIL rnd%0d_nbytes got=%0d exp=%0d", round, gn - gbase, nb); else n_pass++;
    for (int i = 0; i < nb; i++) begin
      e1 = pack(nq[2*i], nq[2*i+1], 1'b1);
      e0 = pack(nq[2*i], nq[2*i+1], 1'b0);
      n_total++; if (g1[(gbase+i)%1024] !== e1) $display("FAIL rnd%0d_lsn1[%0d] got=%h exp=%h", round, i, g1[(gbase+i)%1024], e1); else n_pass++;
      n_total++; if (g0[(gbase+i)%1024] !== e0) $display("FAIL rnd%0d_lsn0[%0d] got=%h exp=%h", round, i, g0[(gbase+i)%1024], e0); else n_pass++;
`ifdef PACKER_PARITY_EN
      n_total++; if (gp1[(gbase+i)%1024] !== ^e1) $display("FAIL rnd%0d_parity[%0d] got=%b exp=%b", round, i, gp1[(gbase+i)%1024], ^e1); else n_pass++;
`endif
    end
    n_total++; if (cnt1 !== 16'(nb)) $display("FAIL rnd%0d_count got=%0d exp=%0d", round, cnt1, nb); else n_pass++;
    n_total++; if (pend1 !== 1'(nq.size() % 2)) $display("FAIL rnd%0d_pending got=%b exp=%0d", round, pend1, nq.size() % 2); else n_pass++;
    n_total++; if (pops - p0 != nq.size()) $display("FAIL rnd%0d_pops got=%0d exp=%0d", round, pops - p0, nq.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_order();
    test_backpressure();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random(r);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
